// File: rtl/conv11_result_writer_pkg.sv
// Shared conv11 definitions: result-writer FSM encoding and the default
// feature-map geometry / requantisation shift used across the conv11 blocks.
package conv11_result_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int C11_OUT_CH  = 16;
    localparam int C11_PIX_NUM = 196;
    localparam int C11_SHIFT   = 8;

endpackage

// File: rtl/conv11_result_writer_if.sv
// Beat input, bias-ROM lookup and feature-buffer write port of the conv11 result writer.
interface conv11_result_writer_if
    import conv11_result_writer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BIAS_W = 16,
    parameter int OUT_W  = 8,
    parameter int CH_W   = 4,
    parameter int ADDR_W = 12
);
    // Handshake: valid-only, no ready. A beat transfers in every cycle in_valid
    // is high; bias_data must answer bias_idx combinationally in that same cycle.
    // A write happens in every cycle wr_en is high, with wr_addr/wr_data valid.
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [CH_W-1:0]   bias_idx;
    logic [BIAS_W-1:0] bias_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [OUT_W-1:0]  wr_data;

    modport slave (
        input  in_valid, in_data, bias_data,
        output bias_idx, wr_en, wr_addr, wr_data
    );

    modport master (
        output in_valid, in_data, bias_data,
        input  bias_idx, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/conv11_result_writer_requant.sv
// conv11_requant: two-stage bias-add/round then shift/ReLU/clamp pipeline;
// each stage carries a valid bit and the beat's write address.
module conv11_requant
    import conv11_result_writer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BIAS_W = 16,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = C11_SHIFT,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [BIAS_W-1:0] bias_data,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [OUT_W-1:0]  out_data
);
    localparam logic [DATA_W:0] RND = {{DATA_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [DATA_W:0] MAX_Q = {{(DATA_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};

    logic                     s1_valid_q, s1_valid_d;
    logic signed [DATA_W:0]   s1_r_q, s1_r_d;
    logic [ADDR_W-1:0]        s1_addr_q, s1_addr_d;
    logic                     s2_valid_q, s2_valid_d;
    logic [OUT_W-1:0]         s2_data_q, s2_data_d;
    logic [ADDR_W-1:0]        s2_addr_q, s2_addr_d;
    logic [DATA_W:0]          sum;
    logic signed [DATA_W:0]   q;

    // One extra bit keeps the bias add exact for any in-range operands.
    always_comb begin
        sum        = {in_data[DATA_W-1], in_data}
                   + {{(DATA_W + 1 - BIAS_W){bias_data[BIAS_W-1]}}, bias_data};
        s1_valid_d = in_valid;
        s1_r_d     = s1_r_q;
        s1_addr_d  = s1_addr_q;
        if (in_valid) begin
            s1_r_d    = $signed(sum + RND);
            s1_addr_d = in_addr;
        end
    end

    always_comb begin
        q          = s1_r_q >>> SHIFT;
        s2_valid_d = s1_valid_q;
        s2_data_d  = s2_data_q;
        s2_addr_d  = s2_addr_q;
        if (s1_valid_q) begin
            s2_addr_d = s1_addr_q;
            if (q[DATA_W]) begin
                s2_data_d = '0;
            end else if (q > MAX_Q) begin
                s2_data_d = MAX_Q[OUT_W-1:0];
            end else begin
                s2_data_d = q[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_r_q     <= '0;
            s1_addr_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_addr_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_r_q     <= s1_r_d;
            s1_addr_q  <= s1_addr_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_addr_q  <= s2_addr_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_addr  = s2_addr_q;
    assign out_data  = s2_data_q;

endmodule

// File: rtl/conv11_result_writer.sv
// conv11 result writer: counts one frame of accumulator beats, requantises
// each beat and writes it to the feature buffer at its linear address.
module conv11_result_writer
    import conv11_result_writer_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int BIAS_W  = 16,
    parameter int OUT_W   = 8,
    parameter int SHIFT   = C11_SHIFT,
    parameter int OUT_CH  = C11_OUT_CH,
    parameter int PIX_NUM = C11_PIX_NUM,
    parameter int ADDR_W  = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    conv11_result_writer_if.slave  bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output state_t                 dbg_state
);
    localparam int CH_W  = $clog2(OUT_CH);
    localparam int PIX_W = $clog2(PIX_NUM);
    localparam logic [CH_W-1:0]   CH_MAX    = CH_W'(OUT_CH - 1);
    localparam logic [PIX_W-1:0]  PIX_MAX   = PIX_W'(PIX_NUM - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_NUM * OUT_CH - 1);

    state_t            state_q;
    logic              busy_q, done_q, err_q, flush_q;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              accept, arm, last_beat;

    assign accept    = bus.in_valid && (state_q == ST_RUN);
    assign arm       = start && (state_q == ST_IDLE);
    assign last_beat = accept && (addr_q == LAST_ADDR);

    always_comb begin
        ch_d   = ch_q;
        pix_d  = pix_q;
        addr_d = addr_q;
        if (arm) begin
            ch_d   = '0;
            pix_d  = '0;
            addr_d = '0;
        end else if (accept) begin
            addr_d = addr_q + 1'b1;
            if (ch_q == CH_MAX) begin
                ch_d  = '0;
                pix_d = (pix_q == PIX_MAX) ? '0 : pix_q + 1'b1;
            end else begin
                ch_d = ch_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q   <= '0;
            pix_q  <= '0;
            addr_q <= '0;
        end else begin
            ch_q   <= ch_d;
            pix_q  <= pix_d;
            addr_q <= addr_d;
        end
    end

    // FLUSH spans two cycles so the final beat leaves stage 2 before DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (last_beat) begin
                        state_q <= ST_FLUSH;
                        flush_q <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (flush_q) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        flush_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            if (bus.in_valid && (state_q != ST_RUN)) begin
                err_q <= 1'b1;
            end else if (arm) begin
                err_q <= 1'b0;
            end
        end
    end

    conv11_requant #(
        .DATA_W (DATA_W),
        .BIAS_W (BIAS_W),
        .OUT_W  (OUT_W),
        .SHIFT  (SHIFT),
        .ADDR_W (ADDR_W)
    ) u_requant (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept),
        .in_data   (bus.in_data),
        .bias_data (bus.bias_data),
        .in_addr   (addr_q),
        .out_valid (bus.wr_en),
        .out_addr  (bus.wr_addr),
        .out_data  (bus.wr_data)
    );

    assign bus.bias_idx = ch_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_conv11_result_writer.sv
// Scoreboard bench for conv11_result_writer: drivers push expected writes,
// a negedge monitor pops and compares each write and each done pulse.
module tb_conv11_result_writer;
    import conv11_result_writer_pkg::*;

    localparam int FRAME = 3136;

    logic   clk;
    logic   rst_n;
    logic   start;
    logic   busy, done, err;
    state_t dbg_state;

    conv11_result_writer_if #(.DATA_W(32), .BIAS_W(16), .OUT_W(8), .CH_W(4), .ADDR_W(12)) bus ();

    conv11_result_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bias ROM model ----------------
    logic [15:0] bias_rom [0:15];
    assign bus.bias_data = bias_rom[bus.bias_idx];

    // ---------------- scoreboard ----------------
    logic [19:0] exp_q[$];
    int          exp_cyc_q[$];
    int          total = 0;
    int          bad = 0;
    logic [11:0] exp_addr;
    int          last_cyc;
    int          done_exp_cyc;
    bit          done_pend = 0;
    int          done_cnt = 0;
    logic [19:0] mon_e;
    int          mon_c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, expv);
        end
    endtask

    function automatic logic [7:0] model(input logic [31:0] d, input logic [15:0] b);
        longint v;
        v = longint'($signed(d)) + longint'($signed(b)) + 64'sd128;
        v = v >>> 8;
        if (v < 0) return 8'd0;
        if (v > 127) return 8'd127;
        return v[7:0];
    endfunction

    always @(negedge clk) begin
        if (bus.wr_en) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%0d data=%0d cyc=%0d", bus.wr_addr, bus.wr_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                if ({bus.wr_addr, bus.wr_data} !== mon_e || cyc != mon_c) begin
                    bad++;
                    $display("FAIL write act addr=%0d data=%0d cyc=%0d exp addr=%0d data=%0d cyc=%0d",
                             bus.wr_addr, bus.wr_data, cyc, mon_e[19:8], mon_e[7:0], mon_c);
                end
            end
        end
        if (done) begin
            total++;
            done_cnt++;
            if (!done_pend || cyc != done_exp_cyc) begin
                bad++;
                $display("FAIL done_timing act cyc=%0d exp cyc=%0d pending=%0d", cyc, done_exp_cyc, done_pend);
            end
            done_pend = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            start = 1'b0;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic pulse_start(input bit rearm);
        @(posedge clk); #1;
        start = 1'b1;
        bus.in_valid = 1'b0;
        if (rearm) exp_addr = '0;
    endtask

    task automatic send_beat(input logic [31:0] d, input bit use_hand, input logic [7:0] hand);
        logic [7:0] e;
        @(posedge clk); #1;
        start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        chk("bias_idx", {28'd0, bus.bias_idx}, {28'd0, exp_addr[3:0]});
        e = use_hand ? hand : model(d, bias_rom[exp_addr[3:0]]);
        exp_q.push_back({exp_addr, e});
        exp_cyc_q.push_back(cyc + 2);
        last_cyc = cyc;
        exp_addr = exp_addr + 12'd1;
    endtask

    task automatic expect_done();
        done_exp_cyc = last_cyc + 3;
        done_pend = 1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || done_pend) && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, {31'd0, (exp_q.size() == 0 && !done_pend)}, 32'd1);
    endtask

    function automatic logic [31:0] pattern(input int i);
        return 32'((i * 1237) % 60000 - 20000);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        exp_addr = '0;
        bias_rom[0] = 16'd24;
        bias_rom[1] = 16'd0;
        bias_rom[2] = 16'd0;
        for (int c = 3; c < 16; c++) bias_rom[c] = 16'(c * 50 - 300);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_outputs", {11'd0, bus.wr_en, bus.wr_addr, bus.wr_data, busy, done, err}, 32'd0);
        chk("rst_bias_idx", {28'd0, bus.bias_idx}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});

        // V4: beat while IDLE is dropped and flags err; start clears it
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data = 32'd5555;
        idle(1);
        chk("err_idle_beat", {31'd0, err}, 32'd1);
        pulse_start(1);
        idle(1);
        chk("err_cleared", {31'd0, err}, 32'd0);
        chk("busy_run", {31'd0, busy}, 32'd1);

        // V1 / V2: hand-computed requantisation, ReLU and clamp
        send_beat(32'd1000, 1, 8'd4);
        send_beat(-32'sd5000, 1, 8'd0);
        send_beat(32'd100000, 1, 8'd127);

        // V6: start during RUN is ignored; gaps keep addresses contiguous
        pulse_start(0);
        for (int i = 3; i < FRAME; i++) begin
            send_beat(pattern(i), 0, 8'd0);
            if ((i % 5) == 0) idle($urandom_range(1, 3));
        end
        expect_done();
        idle(1);
        chk("busy_flush", {31'd0, busy}, 32'd1);
        drain("frame_a_drain");
        chk("frame_a_done_cnt", done_cnt, 32'd1);
        chk("frame_a_err", {31'd0, err}, 32'd0);
        chk("frame_a_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        done_cnt = 0;

        // V3: full frame back to back
        pulse_start(1);
        for (int i = 0; i < FRAME; i++) send_beat(pattern(i * 7 + 11), 0, 8'd0);
        expect_done();
        idle(1);
        drain("frame_b_drain");
        chk("frame_b_done_cnt", done_cnt, 32'd1);
        chk("frame_b_busy", {31'd0, busy}, 32'd0);
        done_cnt = 0;

        // V5: reset mid-frame abandons it
        pulse_start(1);
        for (int i = 0; i < 100; i++) send_beat(pattern(i + 3), 0, 8'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        #1;
        chk("midrst_outputs", {11'd0, bus.wr_en, bus.wr_addr, bus.wr_data, busy, done, err}, 32'd0);
        chk("midrst_bias_idx", {28'd0, bus.bias_idx}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(10);
        chk("post_rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        pulse_start(1);
        for (int i = 0; i < 20; i++) send_beat(pattern(i + 500), 0, 8'd0);
        idle(1);
        drain("restart_drain");
        chk("restart_busy", {31'd0, busy}, 32'd1);
        chk("restart_done_cnt", done_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv11_result_writer.md
CONV11_RESULT_WRITER -- requirements
Module: conv11_result_writer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  DATA_W, 32, accumulator width of in_data (signed)
  BIAS_W, 16, bias width (signed)
  OUT_W, 8, written feature width
  SHIFT, 8, requantisation right-shift (>=1)
  OUT_CH, 16, output channels per pixel
  PIX_NUM, 196, pixels per feature map (14x14)
  ADDR_W, 12, write address width (>= clog2(PIX_NUM*OUT_CH))
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  start  in  1  one-cycle pulse; arms a new frame
  in_valid  in  1  beat strobe, driven by the conv11 output stage's output_valid
  in_data  in  DATA_W  signed accumulator, qualified by in_valid
  bias_idx  out  clog2(OUT_CH)  channel of the next expected beat; drives the external bias ROM
  bias_data  in  BIAS_W  signed bias for bias_idx, combinational, valid with in_valid
  wr_en  out  1  feature-buffer write strobe
  wr_addr  out  ADDR_W  write address
  wr_data  out  OUT_W  requantised, ReLU'd value
  busy  out  1  high in RUN and FLUSH
  done  out  1  one-cycle pulse at frame completion
  err  out  1  sticky: beat received outside RUN

Function
REQ-003 FSM states SHALL be IDLE, RUN, FLUSH, DONE.
REQ-004 IDLE->RUN SHALL occur on start; start in any other state SHALL be ignored.
REQ-005 In RUN, each in_valid beat SHALL be accepted; no back-pressure exists, so every cycle may carry a beat.
REQ-006 Channel counter ch (0..OUT_CH-1) SHALL increment per accepted beat and wrap to 0; pixel counter (0..PIX_NUM-1) SHALL increment on ch wrap; bias_idx SHALL equal ch.
REQ-007 Beat address SHALL be pixel*OUT_CH+ch, kept as a linear counter incremented per beat, cleared on start.
REQ-008 RUN->FLUSH SHALL occur in the cycle the beat at address PIX_NUM*OUT_CH-1 is accepted.
REQ-009 FLUSH SHALL last exactly 2 cycles, draining the pipeline, then move to DONE; DONE SHALL last 1 cycle with done=1, then move to IDLE.
REQ-010 Stage 1 (registered): s = in_data + sign-extended bias_data, at DATA_W+1 bits, then r = s + 2^(SHIFT-1).
REQ-011 Stage 2 (registered): q = r >>> SHIFT (arithmetic); q<0 -> 0; q > 2^(OUT_W-1)-1 -> 2^(OUT_W-1)-1; wr_data = q[OUT_W-1:0].
REQ-012 Latency SHALL be 2 cycles: a beat accepted at cycle N produces wr_en=1 with its address and data at cycle N+2.
REQ-013 wr_addr SHALL travel with the beat through both stages; wr_en SHALL be 0 whenever no beat occupies stage 2.
REQ-014 in_valid in IDLE, FLUSH or DONE SHALL be dropped (no write, no counter change) and SHALL set err; start SHALL clear err.
REQ-015 The last write SHALL occur in the final FLUSH cycle; done SHALL follow one cycle later.

Reset
REQ-016 rst_n low SHALL asynchronously force the state to IDLE, clear the counters and pipeline valids, and drive wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0 and bias_idx=0.
REQ-017 Reset asserted mid-frame SHALL abandon the frame; after release, no write or done SHALL occur until a new start.

Structure
REQ-018 A shared package SHALL hold the FSM state encoding and the default OUT_CH/PIX_NUM/SHIFT constants shared with the other conv11 blocks.
REQ-019 The requantise/ReLU/clamp datapath SHALL be a sub-module named conv11_requant (2-stage, valid-tagged).

Verification
REQ-020 Bench SHALL cover:
  V1 start; one beat in_data=1000, bias=24, SHIFT=8 -> 2 cycles later wr_en=1, wr_addr=0, wr_data=4 (1024+128=1152, >>8=4).
  V2 in_data=-5000, bias=0 -> wr_data=0; in_data=100000, bias=0 -> wr_data=127.
  V3 Full frame of 3136 back-to-back beats -> 3136 writes at addresses 0..3135 in order, bias_idx cycling 0..15, done pulses once, 3 cycles after the last beat.
  V4 in_valid while IDLE -> no wr_en, err=1; next start -> err=0.
  V5 rst_n low after 100 beats -> all outputs 0 immediately; no writes until a new start; the next frame restarts at address 0.
  V6 start during RUN, and in_valid gaps of 1-3 cycles -> start ignored, addresses remain contiguous.
